// File: rtl/complex_instr_sequencer.sv
// Holds one fetched instruction and steps the complex decoder through its micro-ops.
// Optional perf counters are enabled with COMPLEX_SEQ_PERF_CNT_EN.
module complex_instr_sequencer #(
  parameter int unsigned INSTR_WIDTH  = 32,
  parameter int unsigned MAX_STEPS    = 3,
  parameter int unsigned SEQ_ID_WIDTH = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_flush,
  input  logic                    i_valid,
  input  logic [INSTR_WIDTH-1:0]  i_instr,
  output logic                    o_ready,
  output logic [INSTR_WIDTH-1:0]  o_dec_instr,
  output logic [1:0]              o_dec_step,
  input  logic                    i_dec_not_complex,
  input  logic                    i_dec_more,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic                    o_last,
  output logic [SEQ_ID_WIDTH-1:0] o_seq_id,
  output logic                    o_seq_err,
  output logic [31:0]             o_uop_cnt,
  output logic [31:0]             o_cplx_cnt
);

  localparam int unsigned STEP_W = ($clog2(MAX_STEPS) < 2) ? 2 : $clog2(MAX_STEPS);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEQ  = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [STEP_W-1:0]       step_q, step_d;
  logic [INSTR_WIDTH-1:0]  instr_q, instr_d;
  logic [SEQ_ID_WIDTH-1:0] seq_id_q, seq_id_d;
  logic                    seq_err_q, seq_err_d;

  logic in_seq, at_max, last_c, fire, ready_c, accept;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      step_q    <= '0;
      instr_q   <= '0;
      seq_id_q  <= '0;
      seq_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      instr_q   <= instr_d;
      seq_id_q  <= seq_id_d;
      seq_err_q <= seq_err_d;
    end
  end

  // Next-state: flush beats fire/accept; a last fire may overlap a new accept
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    instr_d   = instr_q;
    seq_id_d  = seq_id_q;
    in_seq    = (state_q == SEQ);
    at_max    = (step_q == STEP_W'(MAX_STEPS - 1));
    last_c    = in_seq && (i_dec_not_complex || !i_dec_more || at_max);
    fire      = in_seq && i_ready && !i_flush;
    ready_c   = !i_flush && (!in_seq || (fire && last_c));
    accept    = i_valid && ready_c;
    seq_err_d = fire && ((i_dec_not_complex && (step_q != '0)) || (i_dec_more && at_max));

    if (i_flush) begin
      state_d = IDLE;
      step_d  = '0;
      if (in_seq) seq_id_d = seq_id_q + SEQ_ID_WIDTH'(1);
    end else begin
      if (fire) begin
        if (last_c) begin
          seq_id_d = seq_id_q + SEQ_ID_WIDTH'(1);
          state_d  = IDLE;
          step_d   = '0;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      if (accept) begin
        instr_d = i_instr;
        step_d  = '0;
        state_d = SEQ;
      end
    end
  end

  assign o_ready     = ready_c;
  assign o_valid     = in_seq;
  assign o_last      = last_c;
  assign o_dec_instr = instr_q;
  assign o_dec_step  = 2'(step_q);
  assign o_seq_id    = seq_id_q;
  assign o_seq_err   = seq_err_q;

`ifdef COMPLEX_SEQ_PERF_CNT_EN
  logic [31:0] uop_cnt_q, cplx_cnt_q;

  // Flush does not touch the counters; only reset clears them
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      uop_cnt_q  <= '0;
      cplx_cnt_q <= '0;
    end else begin
      if (fire) uop_cnt_q <= uop_cnt_q + 32'(1);
      if (fire && last_c && (step_q != '0)) cplx_cnt_q <= cplx_cnt_q + 32'(1);
    end
  end

  assign o_uop_cnt  = uop_cnt_q;
  assign o_cplx_cnt = cplx_cnt_q;
`else
  assign o_uop_cnt  = 32'd0;
  assign o_cplx_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_complex_instr_sequencer.sv
// Directed bench for complex_instr_sequencer: cycle vector table plus reset/wrap sequences.
module tb_complex_instr_sequencer;

  localparam logic [31:0] AMO  = 32'h0020A1AF;
  localparam logic [31:0] ADDI = 32'h00108093;
  localparam logic [31:0] JUNK = 32'hDEADBEEF;

  logic        i_clk = 1'b0;
  logic        i_rst, i_flush, i_valid, i_dec_not_complex, i_dec_more, i_ready;
  logic [31:0] i_instr;
  logic        o_ready, o_valid, o_last, o_seq_err;
  logic [31:0] o_dec_instr, o_uop_cnt, o_cplx_cnt;
  logic [1:0]  o_dec_step;
  logic [3:0]  o_seq_id;

  int n_chk  = 0;
  int n_fail = 0;
  int m_uop  = 0;
  int m_cplx = 0;

  typedef struct {
    logic        valid;
    logic [31:0] instr;
    logic        nc, more, rdy, flush;
    logic        e_ready, e_valid;
    logic [1:0]  e_step;
    logic        e_last;
    logic [3:0]  e_seq;
    logic        e_err;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vecs[$];

  complex_instr_sequencer dut (
    .i_clk             (i_clk),
    .i_rst             (i_rst),
    .i_flush           (i_flush),
    .i_valid           (i_valid),
    .i_instr           (i_instr),
    .o_ready           (o_ready),
    .o_dec_instr       (o_dec_instr),
    .o_dec_step        (o_dec_step),
    .i_dec_not_complex (i_dec_not_complex),
    .i_dec_more        (i_dec_more),
    .o_valid           (o_valid),
    .i_ready           (i_ready),
    .o_last            (o_last),
    .o_seq_id          (o_seq_id),
    .o_seq_err         (o_seq_err),
    .o_uop_cnt         (o_uop_cnt),
    .o_cplx_cnt        (o_cplx_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic add(input logic v, input logic [31:0] ins, input logic nc, input logic more,
                     input logic rdy, input logic fl, input logic er, input logic ev,
                     input logic [1:0] es, input logic el, input logic [3:0] eq,
                     input logic ee, input logic [31:0] ei);
    vec_t t;
    t = '{v, ins, nc, more, rdy, fl, er, ev, es, el, eq, ee, ei};
    vecs.push_back(t);
  endtask

  task automatic chk_perf(input string tag);
`ifdef COMPLEX_SEQ_PERF_CNT_EN
    chk({tag, " uop_cnt"}, o_uop_cnt, 32'(m_uop));
    chk({tag, " cplx_cnt"}, o_cplx_cnt, 32'(m_cplx));
`else
    chk({tag, " uop_cnt"}, o_uop_cnt, 32'd0);
    chk({tag, " cplx_cnt"}, o_cplx_cnt, 32'd0);
`endif
  endtask

  // One instruction of nsteps micro-ops, downstream always ready
  task automatic run_instr(input int idx, input logic [31:0] ins, input int nsteps, input logic [3:0] eseq);
    i_valid = 1'b1; i_instr = ins; i_dec_not_complex = 1'b0; i_dec_more = 1'b0; i_ready = 1'b1;
    #1;
    chk($sformatf("run%0d accept ready", idx), 32'(o_ready), 32'd1);
    tick();
    i_valid = 1'b0;
    for (int s = 0; s < nsteps; s++) begin
      i_dec_not_complex = (nsteps == 1);
      i_dec_more        = (s < nsteps - 1);
      #1;
      chk($sformatf("run%0d s%0d valid", idx, s), 32'(o_valid), 32'd1);
      chk($sformatf("run%0d s%0d step", idx, s), 32'(o_dec_step), 32'(s));
      chk($sformatf("run%0d s%0d last", idx, s), 32'(o_last), 32'(s == nsteps - 1));
      chk($sformatf("run%0d s%0d seq_id", idx, s), 32'(o_seq_id), 32'(eseq));
      tick();
    end
    m_uop += nsteps;
    if (nsteps > 1) m_cplx++;
  endtask

  initial begin
    // valid instr nc more rdy flush | ready valid step last seq err instr
    add(1, AMO,  0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 32'h0);   // accept AMO
    add(0, 0,    0, 1, 1, 0,  0, 1, 0, 0, 0, 0, AMO);
    add(0, 0,    0, 1, 1, 0,  0, 1, 1, 0, 0, 0, AMO);
    add(0, 0,    0, 0, 1, 0,  1, 1, 2, 1, 0, 0, AMO);     // last at step 2
    add(1, ADDI, 0, 0, 1, 0,  1, 0, 0, 0, 1, 0, AMO);
    add(1, AMO,  1, 0, 1, 0,  1, 1, 0, 1, 1, 0, ADDI);    // simple + back-to-back accept
    add(0, 0,    0, 1, 1, 0,  0, 1, 0, 0, 2, 0, AMO);
    add(0, 0,    0, 1, 0, 0,  0, 1, 1, 0, 2, 0, AMO);     // stall x3
    add(0, 0,    0, 1, 0, 0,  0, 1, 1, 0, 2, 0, AMO);
    add(0, 0,    0, 1, 0, 0,  0, 1, 1, 0, 2, 0, AMO);
    add(0, 0,    0, 1, 1, 0,  0, 1, 1, 0, 2, 0, AMO);
    add(0, 0,    0, 0, 1, 0,  1, 1, 2, 1, 2, 0, AMO);
    add(1, AMO,  0, 0, 1, 0,  1, 0, 0, 0, 3, 0, AMO);
    add(0, 0,    0, 1, 1, 0,  0, 1, 0, 0, 3, 0, AMO);
    add(1, JUNK, 0, 1, 1, 1,  0, 1, 1, 0, 3, 0, AMO);     // flush at step 1
    add(1, AMO,  0, 0, 1, 0,  1, 0, 0, 0, 4, 0, AMO);
    add(0, 0,    0, 1, 1, 0,  0, 1, 0, 0, 4, 0, AMO);
    add(0, 0,    0, 1, 1, 0,  0, 1, 1, 0, 4, 0, AMO);
    add(0, 0,    0, 1, 1, 0,  1, 1, 2, 1, 4, 0, AMO);     // more=1 at max step
    add(0, 0,    0, 0, 1, 0,  1, 0, 0, 0, 5, 1, AMO);
    add(1, AMO,  0, 0, 1, 0,  1, 0, 0, 0, 5, 0, AMO);
    add(0, 0,    0, 1, 1, 0,  0, 1, 0, 0, 5, 0, AMO);
    add(0, 0,    1, 0, 1, 0,  1, 1, 1, 1, 5, 0, AMO);     // not_complex at step 1
    add(0, 0,    0, 0, 1, 0,  1, 0, 0, 0, 6, 1, AMO);
    add(1, ADDI, 0, 0, 1, 1,  0, 0, 0, 0, 6, 0, AMO);     // flush while idle
    add(0, 0,    0, 0, 1, 0,  1, 0, 0, 0, 6, 0, AMO);

    i_rst = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_instr = '0;
    i_dec_not_complex = 1'b0; i_dec_more = 1'b0; i_ready = 1'b0;
    #12;
    chk("reset ready", 32'(o_ready), 32'd1);
    chk("reset valid", 32'(o_valid), 32'd0);
    chk("reset step", 32'(o_dec_step), 32'd0);
    chk("reset instr", o_dec_instr, 32'd0);
    chk("reset seq_id", 32'(o_seq_id), 32'd0);
    chk("reset seq_err", 32'(o_seq_err), 32'd0);
    chk_perf("reset");
    tick();
    i_rst = 1'b0;

    foreach (vecs[i]) begin
      i_valid = vecs[i].valid; i_instr = vecs[i].instr;
      i_dec_not_complex = vecs[i].nc; i_dec_more = vecs[i].more;
      i_ready = vecs[i].rdy; i_flush = vecs[i].flush;
      #1;
      chk($sformatf("v%0d ready", i), 32'(o_ready), 32'(vecs[i].e_ready));
      chk($sformatf("v%0d valid", i), 32'(o_valid), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d step", i), 32'(o_dec_step), 32'(vecs[i].e_step));
      chk($sformatf("v%0d last", i), 32'(o_last), 32'(vecs[i].e_last));
      chk($sformatf("v%0d seq_id", i), 32'(o_seq_id), 32'(vecs[i].e_seq));
      chk($sformatf("v%0d seq_err", i), 32'(o_seq_err), 32'(vecs[i].e_err));
      chk($sformatf("v%0d dec_instr", i), o_dec_instr, vecs[i].e_instr);
      if (vecs[i].e_valid && vecs[i].rdy && !vecs[i].flush) begin
        m_uop++;
        if (vecs[i].e_last && vecs[i].e_step != 2'd0) m_cplx++;
      end
      tick();
    end
    i_flush = 1'b0; i_valid = 1'b0;
    chk_perf("table");

    // Async reset in the middle of a complex instruction
    i_valid = 1'b1; i_instr = AMO; i_ready = 1'b1; i_dec_not_complex = 1'b0; i_dec_more = 1'b1;
    tick();
    i_valid = 1'b0;
    tick();
    #1;
    chk("pre-rst step", 32'(o_dec_step), 32'd1);
    #2;
    i_rst = 1'b1;
    #1;
    chk("mid-rst valid", 32'(o_valid), 32'd0);
    chk("mid-rst ready", 32'(o_ready), 32'd1);
    chk("mid-rst step", 32'(o_dec_step), 32'd0);
    chk("mid-rst last", 32'(o_last), 32'd0);
    chk("mid-rst instr", o_dec_instr, 32'd0);
    chk("mid-rst seq_id", 32'(o_seq_id), 32'd0);
    m_uop = 0; m_cplx = 0;
    chk_perf("mid-rst");
    tick();
    tick();
    i_rst = 1'b0;
    i_dec_more = 1'b0;

    // 17 instructions of 1/2/3 steps so the tag wraps through 15 -> 0
    for (int k = 0; k < 17; k++)
      run_instr(k, (k % 3 == 0) ? ADDI : AMO, (k % 3) + 1, 4'(k % 16));
    #1;
    chk("wrap seq_id", 32'(o_seq_id), 32'd1);
    chk("wrap idle", 32'(o_valid), 32'd0);
    chk_perf("wrap");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
